// File: rtl/bsg_fsb_node_wide_adapter.sv
// bsg_fsb_node_wide_adapter: client-side FSB node adapter.
// Reassembles els_p inbound flits per message and splits outbound messages.
module bsg_fsb_node_wide_adapter #(
   parameter int width_p    = 13,
   parameter int id_width_p = 4,
   parameter int dest_id_p  = 0,
   parameter int els_p      = 4,
   localparam int payload_w = width_p - id_width_p - 1,
   localparam int msg_w     = els_p * payload_w
) (
   input  logic               clk_i,
   input  logic               reset_i,

   input  logic               fsb_v_i,
   input  logic [width_p-1:0] fsb_data_i,
   output logic               fsb_ready_o,

   output logic               fsb_v_o,
   output logic [width_p-1:0] fsb_data_o,
   input  logic               fsb_yumi_i,

   output logic               msg_v_o,
   output logic [msg_w-1:0]   msg_data_o,
   input  logic               msg_yumi_i,

   input  logic               msg_v_i,
   input  logic [msg_w-1:0]   msg_data_i,
   output logic               msg_ready_o
);

   localparam int cnt_w = (els_p > 1) ? $clog2(els_p) : 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(els_p - 1);
   localparam logic [id_width_p-1:0] dest_id = id_width_p'(dest_id_p);

   logic [cnt_w-1:0]                      in_cnt_r;
   logic                                  in_full_r;
   logic [els_p-1:0][payload_w-1:0]       in_buf_r;
   logic                                  in_accept;

   logic [cnt_w-1:0]                      out_cnt_r;
   logic                                  out_busy_r;
   logic [els_p-1:0][payload_w-1:0]       out_buf_r;
   logic                                  out_load;

   // Header and cmd bit are already filtered upstream by the gateway.
   logic [width_p-payload_w-1:0]          unused_hdr;
   assign unused_hdr = fsb_data_i[width_p-1:payload_w];

   assign fsb_ready_o = ~reset_i & ~in_full_r;
   assign in_accept   = fsb_v_i & fsb_ready_o;
   assign msg_v_o     = in_full_r;
   assign msg_data_o  = in_buf_r;

   assign msg_ready_o = ~reset_i & ~out_busy_r;
   assign out_load    = msg_v_i & msg_ready_o;
   assign fsb_v_o     = out_busy_r;
   assign fsb_data_o  = {dest_id, 1'b0, out_buf_r[out_cnt_r]};

   // Inbound slice counter and message-full flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         in_cnt_r  <= '0;
         in_full_r <= 1'b0;
      end else if (in_accept) begin
         if (in_cnt_r == last_cnt) begin
            in_full_r <= 1'b1;
            in_cnt_r  <= '0;
         end else begin
            in_cnt_r  <= in_cnt_r + 1'b1;
         end
      end else if (msg_yumi_i) begin
         in_full_r <= 1'b0;
      end
   end

   // Inbound payload capture; flit 0 lands in the low slice.
   always_ff @(posedge clk_i) begin
      if (in_accept) begin
         in_buf_r[in_cnt_r] <= fsb_data_i[payload_w-1:0];
      end
   end

   // Outbound slice counter and busy flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_cnt_r  <= '0;
         out_busy_r <= 1'b0;
      end else if (out_load) begin
         out_cnt_r  <= '0;
         out_busy_r <= 1'b1;
      end else if (fsb_yumi_i) begin
         if (out_cnt_r == last_cnt) begin
            out_busy_r <= 1'b0;
         end else begin
            out_cnt_r  <= out_cnt_r + 1'b1;
         end
      end
   end

   // Outbound message latch.
   always_ff @(posedge clk_i) begin
      if (out_load) begin
         out_buf_r <= msg_data_i;
      end
   end

   // Handshake and parameter sanity checks.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(fsb_yumi_i && !fsb_v_o))
            else $error("fsb_yumi_i without fsb_v_o");
         assert (!(msg_yumi_i && !msg_v_o))
            else $error("msg_yumi_i without msg_v_o");
         assert (payload_w >= 1)
            else $error("payload_w < 1");
      end
   end

endmodule

// File: tb/tb_bsg_fsb_node_wide_adapter.sv
// tb_bsg_fsb_node_wide_adapter: scoreboard bench for the wide adapter.
// Model queues expected messages/flits; a negedge monitor pops and compares.
module tb_bsg_fsb_node_wide_adapter;

   localparam int W    = 13;
   localparam int IDW  = 4;
   localparam int DEST = 5;
   localparam int ELS  = 4;
   localparam int PW   = W - IDW - 1;
   localparam int MW   = ELS * PW;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          fsb_v_i = 1'b0;
   logic [W-1:0]  fsb_data_i = '0;
   logic          fsb_ready_o;
   logic          fsb_v_o;
   logic [W-1:0]  fsb_data_o;
   logic          fsb_yumi_i;
   logic          msg_v_o;
   logic [MW-1:0] msg_data_o;
   logic          msg_yumi_i;
   logic          msg_v_i = 1'b0;
   logic [MW-1:0] msg_data_i = '0;
   logic          msg_ready_o;

   logic          fsb_yumi_en = 1'b0;
   logic          msg_yumi_en = 1'b0;

   assign fsb_yumi_i = fsb_v_o & fsb_yumi_en;
   assign msg_yumi_i = msg_v_o & msg_yumi_en;

   always #5 clk = ~clk;

   bsg_fsb_node_wide_adapter #(
      .width_p(W), .id_width_p(IDW), .dest_id_p(DEST), .els_p(ELS)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i), .fsb_ready_o(fsb_ready_o),
      .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_yumi_i(fsb_yumi_i),
      .msg_v_o(msg_v_o), .msg_data_o(msg_data_o), .msg_yumi_i(msg_yumi_i),
      .msg_v_i(msg_v_i), .msg_data_i(msg_data_i), .msg_ready_o(msg_ready_o)
   );

   int errors = 0;
   int checks = 0;

   logic [MW-1:0] exp_msg_q[$];
   logic [W-1:0]  exp_flit_q[$];
   logic [PW-1:0] in_pl[$];

   logic          prev_v = 1'b0;
   logic          prev_yumi = 1'b0;
   logic [W-1:0]  prev_data = '0;
   logic [MW-1:0] m;
   logic [W-1:0]  f;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model and monitor.
   always @(negedge clk) begin
      if (reset_i) begin
         exp_msg_q.delete();
         exp_flit_q.delete();
         in_pl.delete();
         prev_v = 1'b0;
      end else begin
         if (prev_v && !prev_yumi) begin
            chk("fsb_v_o held", fsb_v_o, 1);
            chk("fsb_data_o stable", fsb_data_o, prev_data);
         end
         if (fsb_v_i && fsb_ready_o) begin
            in_pl.push_back(fsb_data_i[PW-1:0]);
            if (in_pl.size() == ELS) begin
               m = '0;
               for (int i = 0; i < ELS; i++) m[i*PW +: PW] = in_pl[i];
               exp_msg_q.push_back(m);
               in_pl.delete();
            end
         end
         if (msg_v_i && msg_ready_o) begin
            for (int i = 0; i < ELS; i++) begin
               f = (W'(DEST) << (W - IDW)) | W'(msg_data_i[i*PW +: PW]);
               exp_flit_q.push_back(f);
            end
         end
         if (msg_v_o && msg_yumi_i) begin
            if (exp_msg_q.size() == 0) begin
               chk("unexpected msg", 1, 0);
            end else begin
               chk("msg_data_o", msg_data_o, exp_msg_q.pop_front());
            end
         end
         if (fsb_v_o && fsb_yumi_i) begin
            if (exp_flit_q.size() == 0) begin
               chk("unexpected flit", 1, 0);
            end else begin
               chk("fsb_data_o", fsb_data_o, exp_flit_q.pop_front());
            end
         end
         prev_v    = fsb_v_o;
         prev_yumi = fsb_yumi_i;
         prev_data = fsb_data_o;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_flit(input logic [PW-1:0] p);
      int n = 0;
      fsb_v_i    = 1'b1;
      fsb_data_i = {5'($urandom), p};
      @(negedge clk);
      while (!fsb_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("fsb_ready_o timeout", 0, 1);
      step();
      fsb_v_i = 1'b0;
   endtask

   task automatic send_msg(input logic [MW-1:0] d);
      int n = 0;
      msg_v_i    = 1'b1;
      msg_data_i = d;
      @(negedge clk);
      while (!msg_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("msg_ready_o timeout", 0, 1);
      step();
      msg_v_i = 1'b0;
   endtask

   task automatic drain();
      msg_yumi_en = 1'b1;
      fsb_yumi_en = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (exp_msg_q.size() == 0 && exp_flit_q.size() == 0) break;
         @(negedge clk);
      end
      chk("msg queue drained", exp_msg_q.size(), 0);
      chk("flit queue drained", exp_flit_q.size(), 0);
      step();
      msg_yumi_en = 1'b0;
      fsb_yumi_en = 1'b0;
   endtask

   logic [W-1:0] exp3[4];
   logic         in_done;
   logic         out_done;

   initial begin
      exp3[0] = 13'hAAA;
      exp3[1] = 13'hABB;
      exp3[2] = 13'hACC;
      exp3[3] = 13'hADD;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst msg_v_o", msg_v_o, 0);
      chk("rst fsb_v_o", fsb_v_o, 0);
      chk("rst fsb_ready_o", fsb_ready_o, 0);
      chk("rst msg_ready_o", msg_ready_o, 0);
      step();
      reset_i = 1'b0;
      @(negedge clk);
      chk("post-rst fsb_ready_o", fsb_ready_o, 1);
      chk("post-rst msg_ready_o", msg_ready_o, 1);
      chk("post-rst msg_v_o", msg_v_o, 0);
      chk("post-rst fsb_v_o", fsb_v_o, 0);
      step();

      // Inbound reassembly
      for (int j = 0; j < ELS; j++) send_flit(8'(8'h11 * (j + 1)));
      repeat (3) begin
         @(negedge clk);
         chk("s2 msg_v_o", msg_v_o, 1);
         chk("s2 msg_data_o", msg_data_o, 32'h44332211);
         chk("s2 fsb_ready_o low", fsb_ready_o, 0);
      end
      step();
      msg_yumi_en = 1'b1;
      step();
      msg_yumi_en = 1'b0;
      @(negedge clk);
      chk("s2 ready after yumi", fsb_ready_o, 1);
      chk("s2 msg_v_o cleared", msg_v_o, 0);
      step();

      // Outbound split
      fsb_yumi_en = 1'b1;
      send_msg(32'hDDCCBBAA);
      for (int j = 0; j < ELS; j++) begin
         @(negedge clk);
         chk("s3 flit", fsb_data_o, exp3[j]);
         chk("s3 msg_ready_o low", msg_ready_o, 0);
      end
      @(negedge clk);
      chk("s3 msg_ready_o back", msg_ready_o, 1);
      chk("s3 fsb_v_o done", fsb_v_o, 0);
      step();

      // Outbound backpressure
      send_msg(32'hDDCCBBAA);
      @(negedge clk);
      chk("s4 flit0", fsb_data_o, exp3[0]);
      step();
      fsb_yumi_en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("s4 held flit", fsb_data_o, exp3[1]);
      end
      step();
      fsb_yumi_en = 1'b1;
      for (int j = 1; j < ELS; j++) begin
         @(negedge clk);
         chk("s4 flit", fsb_data_o, exp3[j]);
      end
      @(negedge clk);
      chk("s4 msg_ready_o back", msg_ready_o, 1);
      step();
      fsb_yumi_en = 1'b0;

      // Full duplex with random stalls
      in_done  = 1'b0;
      out_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               for (int j = 0; j < ELS; j++) begin
                  send_flit(k == 0 ? 8'(8'h11 * (j + 1)) : 8'($urandom));
                  repeat ($urandom_range(0, 2)) step();
               end
            end
            in_done = 1'b1;
         end
         begin
            for (int k = 0; k < 25; k++) begin
               send_msg(k == 0 ? 32'hDDCCBBAA : 32'($urandom));
               repeat ($urandom_range(0, 3)) step();
            end
            out_done = 1'b1;
         end
         begin
            while (!(in_done && out_done)) begin
               step();
               msg_yumi_en = 1'($urandom_range(0, 1));
               fsb_yumi_en = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();
      chk("no partial inbound", in_pl.size(), 0);

      // Reset mid-operation
      fork
         begin
            send_flit(8'hAA);
            send_flit(8'hBB);
         end
         send_msg(32'($urandom));
      join
      fsb_yumi_en = 1'b1;
      @(negedge clk);
      step();
      fsb_yumi_en = 1'b0;
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("s6 no msg", msg_v_o, 0);
         chk("s6 no flit", fsb_v_o, 0);
      end
      step();
      for (int j = 1; j <= ELS; j++) send_flit(8'(j));
      @(negedge clk);
      chk("s6 msg_v_o", msg_v_o, 1);
      chk("s6 msg_data_o", msg_data_o, 32'h04030201);
      step();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bsg_fsb_node_wide_adapter.md
# bsg_fsb_node_wide_adapter

Client-side adapter that sits directly below one node port of the front side bus. It consumes the node's inbound flit stream and reassembles `els_p` consecutive flits into one wide message for the client. In the other direction it splits one wide client message into `els_p` outbound flits that carry a fixed destination header. Inbound and outbound paths are independent and full duplex, matching the bus.

## Interface
- `width_p`, 13, FSB flit width.
- `id_width_p`, 4, destination id field width.
- `dest_id_p`, 0, destination id stamped on every outbound flit.
- `els_p`, 4, flits per wide message; must be ≥ 1.
- Derived: `payload_w = width_p - id_width_p - 1`; `msg_w = els_p * payload_w`.
- Flit format: `[width_p-1 -: id_width_p]` = dest id; next bit = cmd (0 = data); low `payload_w` bits = payload.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `fsb_v_i`  in  1  inbound flit valid; driven by the node's `v_o`.
- `fsb_data_i`  in  `width_p`  inbound flit.
- `fsb_ready_o`  out  1  inbound ready; drives the node's `ready_i`.
- `fsb_v_o`  out  1  outbound flit valid; drives the node's `v_i`.
- `fsb_data_o`  out  `width_p`  outbound flit.
- `fsb_yumi_i`  in  1  outbound flit consumed; driven by the node's `yumi_o`.
- `msg_v_o`  out  1  reassembled message valid.
- `msg_data_o`  out  `msg_w`  reassembled message.
- `msg_yumi_i`  in  1  client consumes the message.
- `msg_v_i`  in  1  client message to send is valid.
- `msg_data_i`  in  `msg_w`  client message to send.
- `msg_ready_o`  out  1  adapter can accept a client message.

## Operation
**Inbound (reassembly)**
- State: `in_cnt_r`, width `BSG_SAFE_CLOG2(els_p)`; `in_full_r`; `in_buf_r[msg_w]`.
- `fsb_ready_o = ~reset_i & ~in_full_r`.
- Accept on `fsb_v_i & fsb_ready_o`:
  - Write the payload to slice `in_cnt_r`. Flit 0 is the least-significant slice.
  - If `in_cnt_r == els_p-1`, set `in_full_r` and clear `in_cnt_r`. Otherwise increment `in_cnt_r`.
- The header and cmd bit of inbound flits are ignored, because the gateway has already filtered cmd packets.
- `msg_v_o = in_full_r`; `msg_data_o = in_buf_r`.
- `msg_yumi_i` clears `in_full_r`.
- No flit is accepted while `in_full_r` is set, including the cycle in which `msg_yumi_i` is asserted.

**Outbound (split)**
- State: `out_cnt_r`; `out_busy_r`; `out_buf_r[msg_w]`.
- `msg_ready_o = ~reset_i & ~out_busy_r`.
- On `msg_v_i & msg_ready_o`: latch `msg_data_i`, set `out_busy_r`, set `out_cnt_r = 0`.
- `fsb_v_o = out_busy_r`.
- `fsb_data_o = {dest_id_p[id_width_p-1:0], 1'b0, out_buf_r slice out_cnt_r}`.
- On `fsb_yumi_i`:
  - If `out_cnt_r == els_p-1`, clear `out_busy_r`.
  - Otherwise increment `out_cnt_r`.
- `fsb_data_o` is stable while `fsb_v_o` is high and no yumi has occurred.

**Reset**
- `in_cnt_r`, `out_cnt_r`, `in_full_r` and `out_busy_r` reset to 0. Data buffers are not reset.
- Output values during and immediately after reset: `msg_v_o=0`, `fsb_v_o=0`.
- `fsb_ready_o` and `msg_ready_o` are 0 while `reset_i` is high and 1 in the first cycle after reset.
- Reset mid-message discards any partial inbound message and any outbound message in flight.

**Assertions (simulation only)**
- `fsb_yumi_i` without `fsb_v_o`.
- `msg_yumi_i` without `msg_v_o`.
- `payload_w < 1`.

## Timing
- Inbound latency: `msg_v_o` rises in the cycle after the last flit is accepted.
  - Peak inbound throughput is `els_p` flits followed by at least 1 yumi cycle.
  - With `msg_yumi_i` in the same cycle that `msg_v_o` rises, the next flit is accepted in the following cycle.
- Outbound: `fsb_v_o` rises in the cycle after the message is accepted.
  - Back-to-back yumis drain the message in `els_p` cycles.
  - `msg_ready_o` rises in the cycle after the last yumi, giving a minimum of `els_p+1` cycles per message.
- No combinational paths:
  - `fsb_v_i` does not feed `fsb_ready_o`.
  - `msg_yumi_i` does not feed `fsb_ready_o`.
  - `fsb_yumi_i` does not feed `msg_ready_o`.
- `els_p=1`: the counters are constant 0, and each flit is a complete message.

## Test plan
Default parameters with `dest_id_p=5` (so `payload_w=8`, `msg_w=32`):
1. **Reset values.** Assert `reset_i` for 3 cycles with all inputs 0 → during reset `msg_v_o=0`, `fsb_v_o=0`, `fsb_ready_o=0`, `msg_ready_o=0`; in the first cycle after reset both readies are 1.
2. **Inbound reassembly.** Send flits with payloads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, with arbitrary headers → `msg_v_o=1` in the next cycle with `msg_data_o=32'h44332211`; `fsb_ready_o=0` until `msg_yumi_i`.
3. **Outbound split.** Send `msg_data_i=32'hDDCCBBAA` with `fsb_yumi_i` held at 1 → `fsb_data_o` = 13'hAAA, 13'hABB, 13'hACC, 13'hADD on consecutive cycles; `msg_ready_o` returns to 1 in the cycle after 13'hADD.
4. **Outbound backpressure.** Repeat scenario 3 with `fsb_yumi_i` held at 0 for 5 cycles before the second flit → 13'hABB is held stable and `out_cnt_r` does not advance.
5. **Full duplex.** Run scenarios 2 and 3 concurrently with interleaved stalls → both complete with identical data and no interaction between the paths.
6. **Reset mid-operation.** Pulse `reset_i` after 2 inbound flits and 1 outbound yumi → no message is produced. A following full 4-flit inbound sequence (0x01–0x04) yields `32'h04030201`, with no residue from the aborted message.
